// File: rtl/memory_access.sv
// MEM stage of the five-stage MIPS pipeline: registers the EX/MEM fields and
// issues one data-cache word access per load/store, stalling until dhit.
module memory_access (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        flush,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_regWr,
    input  logic        ex_halt,
    input  logic [1:0]  ex_regSel,
    input  logic [4:0]  ex_regDst,
    input  logic [31:0] ex_nPC,
    input  logic [31:0] ex_ALUOut,
    input  logic [31:0] ex_lui,
    input  logic [31:0] ex_storeData,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        dREN,
    output logic        dWEN,
    output logic        regWr,
    output logic        halt,
    output logic [1:0]  regSel,
    output logic [4:0]  regDst,
    output logic [31:0] nPC,
    output logic [31:0] ALUOut,
    output logic [31:0] lui,
    output logic [31:0] ld_data,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        advance;
    logic        mem_op;
    logic [31:0] store_q;
    logic [31:0] ld_q;

    // Cache handshake: dmemREN/dmemWEN act as valid and dhit as ready. The
    // request stays stable until the cycle dhit is high and drops the cycle after.
    assign mem_stall = (state == REQ) && !dhit;
    assign advance   = ihit && !mem_stall;
    assign mem_op    = ex_dREN || ex_dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dREN    <= 1'b0;
            dWEN    <= 1'b0;
            regWr   <= 1'b0;
            halt    <= 1'b0;
            regSel  <= 2'd0;
            regDst  <= 5'd0;
            nPC     <= 32'd0;
            ALUOut  <= 32'd0;
            lui     <= 32'd0;
            store_q <= 32'd0;
        end else if (flush) begin
            // halt survives a squash so a captured halt is never lost
            dREN    <= 1'b0;
            dWEN    <= 1'b0;
            regWr   <= 1'b0;
            regSel  <= 2'd0;
            regDst  <= 5'd0;
            nPC     <= 32'd0;
            ALUOut  <= 32'd0;
            lui     <= 32'd0;
            store_q <= 32'd0;
        end else if (advance) begin
            dREN    <= ex_dREN;
            dWEN    <= ex_dWEN && !ex_dREN;
            regWr   <= ex_regWr;
            halt    <= halt || ex_halt;
            regSel  <= ex_regSel;
            regDst  <= ex_regDst;
            nPC     <= ex_nPC;
            ALUOut  <= ex_ALUOut;
            lui     <= ex_lui;
            store_q <= ex_storeData;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ld_q <= 32'd0;
        end else if (flush) begin
            ld_q <= 32'd0;
        end else if (state == REQ && dhit) begin
            ld_q <= dmemload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A dhit edge that also advances may capture the next memory op directly.
    always_comb begin
        next_state = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (advance) begin
                    next_state = mem_op ? REQ : IDLE;
                end
            end
            REQ: begin
                dmemREN = dREN;
                dmemWEN = dWEN;
                if (dhit) begin
                    next_state = (advance && mem_op) ? REQ : DONE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    assign dmemaddr  = {ALUOut[31:2], 2'b00};
    assign dmemstore = store_q;
    assign ld_data   = (state == REQ) ? dmemload : ld_q;
    assign state_dbg = state;

endmodule
